// File: rtl/ctl_reg_bank.sv
// Control/status register bank for an IO-bus peripheral: control registers, go/ERR command, W1C event status.
// Define CTL_BANK_IRQ_EN to add the MASK register at NUM_CTL+2 and a masked irq_o.
module ctl_reg_bank #(
    parameter int unsigned       DATA_W  = 32,
    parameter int unsigned       NUM_CTL = 4,
    parameter int unsigned       ADDR_W  = 4,
    parameter int unsigned       EVT_W   = 8,
    parameter logic [DATA_W-1:0] CTL_RST = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      sel_i,
    input  logic                      wr_i,
    input  logic                      rd_i,
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      rvalid_o,
    output logic [NUM_CTL*DATA_W-1:0] ctl_o,
    output logic                      go_o,
    input  logic                      busy_i,
    input  logic [EVT_W-1:0]          evt_i,
    output logic                      irq_o
);

    localparam logic [ADDR_W-1:0] ADDR_CMD = ADDR_W'(NUM_CTL);
    localparam logic [ADDR_W-1:0] ADDR_STS = ADDR_W'(NUM_CTL + 1);

    logic [DATA_W-1:0] r_ctl [NUM_CTL];
    logic [EVT_W-1:0]  r_sts;
    logic              r_err;
    logic              r_go;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              w_wr;
    logic              w_rd;
    logic              w_cmd_wr;
    logic              w_go_req;
    logic [EVT_W-1:0]  w_sts_clr;
    logic [EVT_W-1:0]  w_sts_nxt;
    logic [DATA_W-1:0] w_rd_val;

    assign w_wr      = sel_i & wr_i;
    assign w_rd      = sel_i & rd_i;
    assign w_cmd_wr  = w_wr && (addr_i == ADDR_CMD);
    assign w_go_req  = w_cmd_wr & wdata_i[0];
    assign w_sts_clr = (w_wr && (addr_i == ADDR_STS)) ? wdata_i[EVT_W-1:0] : '0;
    // Events are OR'ed in after the clear so a simultaneous event wins.
    assign w_sts_nxt = (r_sts & ~w_sts_clr) | evt_i;

`ifdef CTL_BANK_IRQ_EN
    localparam logic [ADDR_W-1:0] ADDR_MSK = ADDR_W'(NUM_CTL + 2);

    logic [EVT_W-1:0] r_msk;
    logic [EVT_W-1:0] w_msk_nxt;
    logic             r_irq;

    assign w_msk_nxt = (w_wr && (addr_i == ADDR_MSK)) ? wdata_i[EVT_W-1:0] : r_msk;

    // irq is computed from next-state values so it rises on the edge that sets the status bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_msk <= '0;
            r_irq <= 1'b0;
        end else begin
            r_msk <= w_msk_nxt;
            r_irq <= |(w_sts_nxt & w_msk_nxt);
        end
    end

    assign irq_o = r_irq;
`else
    assign irq_o = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_CTL; k++) begin
                r_ctl[k] <= CTL_RST;
            end
        end else begin
            for (int k = 0; k < NUM_CTL; k++) begin
                if (w_wr && (addr_i == ADDR_W'(k))) begin
                    r_ctl[k] <= wdata_i;
                end
            end
        end
    end

    // Command and status: a rejected go sets ERR ahead of any clear in the same write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_go  <= 1'b0;
            r_err <= 1'b0;
            r_sts <= '0;
        end else begin
            r_go  <= w_go_req & ~busy_i;
            r_sts <= w_sts_nxt;
            if (w_go_req && busy_i) begin
                r_err <= 1'b1;
            end else if (w_cmd_wr && wdata_i[1]) begin
                r_err <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        for (int k = 0; k < NUM_CTL; k++) begin
            if (addr_i == ADDR_W'(k)) begin
                w_rd_val = r_ctl[k];
            end
        end
        if (addr_i == ADDR_CMD) begin
            w_rd_val = DATA_W'({r_err, busy_i});
        end
        if (addr_i == ADDR_STS) begin
            w_rd_val = DATA_W'(r_sts);
        end
`ifdef CTL_BANK_IRQ_EN
        if (addr_i == ADDR_MSK) begin
            w_rd_val = DATA_W'(r_msk);
        end
`endif
    end

    // Read data samples pre-write register values and holds until the next read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    for (genvar g = 0; g < NUM_CTL; g++) begin : g_ctl
        assign ctl_o[g*DATA_W +: DATA_W] = r_ctl[g];
    end

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;
    assign go_o     = r_go;

endmodule

// File: tb/tb_ctl_reg_bank.sv
// Directed self-checking bench for ctl_reg_bank (default parameters; IRQ checks follow CTL_BANK_IRQ_EN).
module tb_ctl_reg_bank;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned NUM_CTL = 4;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned EVT_W   = 8;

    localparam logic [ADDR_W-1:0] A_CMD = 4'd4;
    localparam logic [ADDR_W-1:0] A_STS = 4'd5;
    localparam logic [ADDR_W-1:0] A_MSK = 4'd6;

    logic                      clk;
    logic                      rst;
    logic                      sel;
    logic                      wr;
    logic                      rd;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         wdata;
    logic [DATA_W-1:0]         rdata;
    logic                      rvalid;
    logic [NUM_CTL*DATA_W-1:0] ctl;
    logic                      go;
    logic                      busy;
    logic [EVT_W-1:0]          evt;
    logic                      irq;

    int n_checks;
    int n_errors;

    ctl_reg_bank #(
        .DATA_W (DATA_W),
        .NUM_CTL(NUM_CTL),
        .ADDR_W (ADDR_W),
        .EVT_W  (EVT_W),
        .CTL_RST(32'h0)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .sel_i   (sel),
        .wr_i    (wr),
        .rd_i    (rd),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .rvalid_o(rvalid),
        .ctl_o   (ctl),
        .go_o    (go),
        .busy_i  (busy),
        .evt_i   (evt),
        .irq_o   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic s, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        sel = s; wr = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        sel = 1'b1; rd = 1'b1; addr = a;
        tick();
        sel = 1'b0; rd = 1'b0;
        check({tag, "_rvalid"}, DATA_W'(rvalid), 32'd1);
        check(tag, rdata, exp);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; sel = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = '0; wdata = '0; busy = 1'b0; evt = '0;
        #22;
        rst = 1'b0;
        check("rst_rdata",  rdata, 32'h0);
        check("rst_rvalid", DATA_W'(rvalid), 32'h0);
        check("rst_go",     DATA_W'(go), 32'h0);
        check("rst_irq",    DATA_W'(irq), 32'h0);
        check("rst_ctl0",   ctl[31:0], 32'h0);

        // Read every address; rvalid must be a single-cycle pulse.
        for (int a = 0; a < 16; a++) begin
            bus_rd($sformatf("rd_all_%0d", a), ADDR_W'(a), 32'h0);
            tick();
            check($sformatf("rd_all_%0d_drop", a), DATA_W'(rvalid), 32'h0);
        end

        bus_wr(1'b1, 4'd2, 32'hA5A5_0001);
        check("ctl2_wr", ctl[95:64], 32'hA5A5_0001);
        bus_rd("ctl2_rd", 4'd2, 32'hA5A5_0001);
        bus_wr(1'b0, 4'd2, 32'h1234_5678);
        check("ctl2_nosel", ctl[95:64], 32'hA5A5_0001);
        check("ctl1_quiet", ctl[63:32], 32'h0);

        // Read and write same address in one cycle returns the old value.
        sel = 1'b1; wr = 1'b1; rd = 1'b1; addr = 4'd0; wdata = 32'h0000_DEAD;
        tick();
        sel = 1'b0; wr = 1'b0; rd = 1'b0;
        check("rw_same_rdata", rdata, 32'h0);
        check("rw_same_ctl0",  ctl[31:0], 32'h0000_DEAD);
        tick();
        check("rdata_hold", rdata, 32'h0);
        bus_rd("ctl0_rd", 4'd0, 32'h0000_DEAD);

        bus_wr(1'b1, 4'd10, 32'hFFFF_FFFF);
        bus_rd("unmapped_rd", 4'd10, 32'h0);

        // Go accepted, rejected, and ERR handling.
        bus_wr(1'b1, A_CMD, 32'h1);
        check("go_pulse", DATA_W'(go), 32'h1);
        tick();
        check("go_end", DATA_W'(go), 32'h0);
        bus_rd("cmd_idle", A_CMD, 32'h0);

        busy = 1'b1;
        bus_wr(1'b1, A_CMD, 32'h1);
        check("go_rejected", DATA_W'(go), 32'h0);
        bus_rd("cmd_err", A_CMD, 32'h3);
        bus_wr(1'b1, A_CMD, 32'h2);
        bus_rd("cmd_err_clr", A_CMD, 32'h1);
        bus_wr(1'b1, A_CMD, 32'h3);
        check("go_rej_set_wins", DATA_W'(go), 32'h0);
        bus_rd("cmd_set_wins", A_CMD, 32'h3);
        busy = 1'b0;
        bus_wr(1'b1, A_CMD, 32'h2);
        bus_rd("cmd_cleared", A_CMD, 32'h0);

        sel = 1'b1; wr = 1'b1; addr = A_CMD; wdata = 32'h1;
        tick();
        check("go_b2b_1", DATA_W'(go), 32'h1);
        tick();
        check("go_b2b_2", DATA_W'(go), 32'h1);
        sel = 1'b0; wr = 1'b0;
        tick();
        check("go_b2b_end", DATA_W'(go), 32'h0);

`ifdef CTL_BANK_IRQ_EN
        bus_wr(1'b1, A_MSK, 32'h04);
        bus_rd("msk_rd", A_MSK, 32'h04);
`else
        bus_wr(1'b1, A_MSK, 32'hFF);
        bus_rd("msk_absent", A_MSK, 32'h0);
`endif

        // Sticky status with W1C and set-wins.
        evt = 8'h04;
        tick();
        evt = 8'h00;
`ifdef CTL_BANK_IRQ_EN
        check("irq_rise", DATA_W'(irq), 32'h1);
`else
        check("irq_tied", DATA_W'(irq), 32'h0);
`endif
        tick(); tick();
        bus_rd("sts_sticky", A_STS, 32'h04);
        evt = 8'h04;
        bus_wr(1'b1, A_STS, 32'h04);
        evt = 8'h00;
        bus_rd("sts_set_wins", A_STS, 32'h04);
        bus_wr(1'b1, A_STS, 32'h04);
        check("irq_after_w1c", DATA_W'(irq), 32'h0);
        bus_rd("sts_w1c", A_STS, 32'h0);

`ifdef CTL_BANK_IRQ_EN
        bus_wr(1'b1, A_MSK, 32'h02);
        evt = 8'h04;
        tick();
        evt = 8'h00;
        check("irq_masked", DATA_W'(irq), 32'h0);
        bus_wr(1'b1, A_STS, 32'hFF);
`endif

        // Asynchronous reset in the middle of a go pulse and a read pulse.
        sel = 1'b1; wr = 1'b1; rd = 1'b1; addr = A_CMD; wdata = 32'h1;
        tick();
        sel = 1'b0; wr = 1'b0; rd = 1'b0;
        check("pre_rst_go",     DATA_W'(go), 32'h1);
        check("pre_rst_rvalid", DATA_W'(rvalid), 32'h1);
        evt = 8'h10;
        tick();
        evt = 8'h00;
        sel = 1'b1; rd = 1'b1; addr = A_STS;
        tick();
        sel = 1'b0; rd = 1'b0;
        check("pre_rst_rdata", rdata, 32'h10);
        bus_wr(1'b1, A_CMD, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_go",     DATA_W'(go), 32'h0);
        check("arst_rvalid", DATA_W'(rvalid), 32'h0);
        check("arst_rdata",  rdata, 32'h0);
        check("arst_ctl0",   ctl[31:0], 32'h0);
        check("arst_ctl2",   ctl[95:64], 32'h0);
        check("arst_irq",    DATA_W'(irq), 32'h0);
        #3;
        rst = 1'b0;
        bus_rd("post_rst_sts", A_STS, 32'h0);
        bus_rd("post_rst_cmd", A_CMD, 32'h0);
        bus_rd("post_rst_ctl2", 4'd2, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ctl_reg_bank.md
# ctl_reg_bank

Parametrised control/status register bank for memory-mapped IO peripherals on the RISC-V monocycle core's IO bus. It generalises the single 2-bit control register to the following:
- NUM_CTL control registers of DATA_W bits.
- A command register with a self-clearing "go" strobe gated by a peripheral busy handshake.
- A sticky write-1-to-clear event status register.
- An optional masked interrupt.

It sits between the bus decoder (sel_i) and one peripheral datapath.

## Interface
Parameters:
- DATA_W, 32, width of every register and of the bus data.
- NUM_CTL, 4, number of plain control registers (1..8).
- ADDR_W, 4, word address width; 2^ADDR_W must be at least NUM_CTL+3.
- EVT_W, 8, number of event inputs/status bits (EVT_W ≤ DATA_W).
- CTL_RST, 0, reset value of every control register (DATA_W bits).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- sel_i  in  1  bank selected by the bus decoder; wr_i and rd_i are ignored when low.
- wr_i  in  1  write strobe.
- rd_i  in  1  read strobe.
- addr_i  in  ADDR_W  word address.
- wdata_i  in  DATA_W  write data.
- rdata_o  out  DATA_W  registered read data.
- rvalid_o  out  1  one-cycle pulse: rdata_o valid.
- ctl_o  out  NUM_CTL*DATA_W  control registers, register k on bits [k*DATA_W +: DATA_W].
- go_o  out  1  one-cycle start pulse to the peripheral.
- busy_i  in  1  peripheral busy.
- evt_i  in  EVT_W  event request levels from the peripheral.
- irq_o  out  1  interrupt request.

## Operation
Address map:
- 0..NUM_CTL-1: control register k, read/write.
- NUM_CTL: command register.
  - Write: bit0=go; bit1=1 clears ERR.
  - Read: bit0=busy_i sampled, bit1=ERR, rest 0.
- NUM_CTL+1: STATUS[EVT_W-1:0].
  - Read returns status, upper bits 0.
  - Write: 1 clears the corresponding bit; 0 has no effect.
- NUM_CTL+2: MASK[EVT_W-1:0], read/write (CTL_BANK_IRQ_EN only).
- Unmapped addresses: reads return 0 with rvalid_o; writes are ignored.

Behaviour:
- A write occurs when sel_i & wr_i at the rising edge. The target register updates at that edge.
- Go:
  - Write to the command register with bit0=1 while busy_i=0: go_o=1 for exactly the next cycle.
  - Same write with busy_i=1: no pulse; ERR sets (sticky).
  - Writing bit1=1 together with a rejected go leaves ERR set (set wins).
- Status:
  - Each cycle, STATUS |= evt_i.
  - A W1C write in the same cycle as evt_i high on that bit leaves the bit set (set wins).
- irq_o = |(STATUS & MASK), driven from registers only (no combinational path from the bus inputs).

## Timing
- Reset (rst_i=1, asynchronous):
  - ctl_o=CTL_RST per register.
  - STATUS=0, MASK=0, ERR=0.
  - rdata_o=0, rvalid_o=0, go_o=0, irq_o=0.
  - Reset mid-pulse kills go_o/rvalid_o immediately.
- Read latency is 1 cycle: sel_i & rd_i at edge N gives rdata_o/rvalid_o after edge N. rdata_o holds until the next read.
- Simultaneous read and write to the same address returns the pre-write value.
- Simultaneous wr_i and rd_i to different addresses: both are performed.
- go_o is high for the cycle after the accepting edge. Back-to-back accepted go writes give back-to-back pulses.
- busy_i is sampled at the write edge only.
- An event at edge N sets STATUS at edge N. irq_o rises in the same cycle the bit becomes set and is visible after edge N.

## Configuration
- CTL_BANK_IRQ_EN defined: MASK register present at NUM_CTL+2; irq_o as above.
- CTL_BANK_IRQ_EN undefined:
  - No MASK flops; address NUM_CTL+2 is treated as unmapped (reads 0, writes ignored).
  - irq_o is tied to 0.
  - STATUS still operates and can be polled.

## Test plan
- Reset, then read all addresses: ctl regs read CTL_RST; command, status and mask read 0; every rvalid_o pulse is 1 cycle, 1 cycle after each rd.
- Write 0xA5A5_0001 to ctl 2: ctl_o[95:64]=0xA5A5_0001 after the edge. Write the same with sel_i=0: no change.
- Command write 0x1 with busy_i=0: go_o is a single 1-cycle pulse. With busy_i=1: no pulse and command reads 0x3. Write 0x2: command reads 0x1 while busy_i=1.
- evt_i=0x04 for one cycle: STATUS=0x04 and stays. Write 0x04 to STATUS while evt_i[2]=1: STATUS stays 0x04. Write again with evt_i=0: STATUS=0.
- IRQ_EN build, MASK=0x04: irq_o rises with STATUS[2] and falls after W1C. With MASK=0x02, irq_o stays 0. Non-IRQ build: irq_o=0 throughout; a read at NUM_CTL+2 returns 0.
- Assert rst_i mid-go-pulse and mid-read: go_o, rvalid_o and all registers drop to reset values without a clock edge.
